gb_lcd_capture: RTL and testbench

Front-end capture stage for the Game Boy LCD bus. It synchronises and deglitches the raw LCD signals (iclk, ihsync, ivsync, idata) into the system clock domain and tracks column and row. It emits one framebuffer write per pixel, with linear address row*H_PIXELS+col. It feeds the write port of the shared framebuffer that the VGA scan-out stage reads, and reports line/frame integrity to the rest of the design.

---
 rtl/gb_lcd_capture.sv | 158 +++++++++++++++
 tb/tb_gb_lcd_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_lcd_capture.sv
// gb_lcd_capture: synchronise/deglitch the Game Boy LCD bus and emit one framebuffer write per pixel.
module gb_lcd_capture #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 144,
   parameter int ADDR_W   = 15,
   parameter int FILTER   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        idata,
   input  logic              iclk,
   input  logic              ihsync,
   input  logic              ivsync,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_data,
   output logic              wr_en,
   output logic              frame_start,
   output logic              line_err,
   output logic              frame_err,
   output logic              locked
);
   localparam int RW = $clog2(V_LINES + 1);
   localparam int CW = $clog2(H_PIXELS + 2);
   localparam logic [RW-1:0] VL  = RW'(V_LINES);
   localparam logic [CW-1:0] HP  = CW'(H_PIXELS);
   localparam logic [CW-1:0] HP1 = CW'(H_PIXELS + 1);

   // bit 2 = vsync, bit 1 = hsync, bit 0 = pixel clock
   logic [2:0] s1_q, f_q, f_d, all1, all0, ev_d, ev_q, ev2_q;
   logic [2:0] win_q [FILTER];
   logic [1:0] d1_q, pd_q, pd2_q;
   logic [1:0] dwin_q [FILTER];
   logic [RW-1:0] row_q, row_d, lines_q, lines_d;
   logic [CW-1:0] col_q, col_d;
   logic armed_q, armed_d, ef_q, ef_d, locked_q, locked_d;
   logic we_q, we_d, fs_q, fs_d, le_q, le_d, fe_q, fe_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [1:0] wd_q, wd_d;

   always_comb begin
      all1 = '1;
      all0 = '1;
      for (int k = 0; k < FILTER; k++) begin
         all1 &= win_q[k];
         all0 &= ~win_q[k];
      end
      f_d  = (f_q | all1) & ~all0;
      ev_d = {f_d[2] & ~f_q[2], f_d[1] & ~f_q[1], ~f_d[0] & f_q[0]};
   end

   // events resolve in the order vsync, hsync, pixel within one cycle
   always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      lines_d  = lines_q;
      armed_d  = armed_q;
      ef_d     = ef_q;
      locked_d = locked_q;
      we_d     = 1'b0;
      fs_d     = 1'b0;
      le_d     = 1'b0;
      fe_d     = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      if (ev2_q[2]) begin
         fs_d = 1'b1;
         if (armed_d && lines_d != VL) begin
            fe_d     = 1'b1;
            locked_d = 1'b0;
         end else if (armed_d && !ef_d) locked_d = 1'b1;
         row_d   = '0;
         col_d   = '0;
         lines_d = '0;
         armed_d = 1'b1;
         ef_d    = 1'b0;
      end
      if (ev2_q[1] && col_d != '0) begin
         row_d   = (row_d == VL) ? row_d : row_d + 1'b1;
         lines_d = (lines_d == VL) ? lines_d : lines_d + 1'b1;
         if (col_d != HP) begin
            le_d     = 1'b1;
            ef_d     = 1'b1;
            locked_d = 1'b0;
         end
         col_d = '0;
      end
      if (ev2_q[0] && armed_d) begin
         if (col_d < HP && row_d < VL) begin
            we_d = 1'b1;
            wa_d = ADDR_W'(row_d) * ADDR_W'(H_PIXELS) + ADDR_W'(col_d);
            wd_d = ~pd2_q;
         end
         col_d = (col_d == HP1) ? col_d : col_d + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         d1_q <= '0;
         for (int k = 0; k < FILTER; k++) begin
            win_q[k]  <= '0;
            dwin_q[k] <= '0;
         end
         f_q      <= '0;
         ev_q     <= '0;
         ev2_q    <= '0;
         pd_q     <= '0;
         pd2_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         lines_q  <= '0;
         armed_q  <= 1'b0;
         ef_q     <= 1'b0;
         locked_q <= 1'b0;
         we_q     <= 1'b0;
         fs_q     <= 1'b0;
         le_q     <= 1'b0;
         fe_q     <= 1'b0;
         wa_q     <= '0;
         wd_q     <= '0;
      end else begin
         s1_q      <= {ivsync, ihsync, iclk};
         d1_q      <= idata;
         win_q[0]  <= s1_q;
         dwin_q[0] <= d1_q;
         for (int k = 1; k < FILTER; k++) begin
            win_q[k]  <= win_q[k-1];
            dwin_q[k] <= dwin_q[k-1];
         end
         f_q      <= f_d;
         ev_q     <= ev_d;
         pd_q     <= dwin_q[FILTER-1];
         ev2_q    <= ev_q;
         pd2_q    <= pd_q;
         row_q    <= row_d;
         col_q    <= col_d;
         lines_q  <= lines_d;
         armed_q  <= armed_d;
         ef_q     <= ef_d;
         locked_q <= locked_d;
         we_q     <= we_d;
         fs_q     <= fs_d;
         le_q     <= le_d;
         fe_q     <= fe_d;
         wa_q     <= wa_d;
         wd_q     <= wd_d;
      end
   end

   assign wr_addr     = wa_q;
   assign wr_data     = wd_q;
   assign wr_en       = we_q;
   assign frame_start = fs_q;
   assign line_err    = le_q;
   assign frame_err   = fe_q;
   assign locked      = locked_q;
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb_gb_lcd_capture: directed scenario tests for gb_lcd_capture (frame height reduced to keep runtime short).
module tb_gb_lcd_capture;
   localparam int H = 160;
   localparam int V = 4;
   localparam int AW = 15;

   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] idata = 2'b00;
   logic iclk = 1'b1, ihsync = 1'b0, ivsync = 1'b0;
   logic [AW-1:0] wr_addr;
   logic [1:0] wr_data;
   logic wr_en, frame_start, line_err, frame_err, locked;

   int tests = 0, fails = 0;
   int wr_cnt, fs_cnt, le_cnt, fe_cnt, seq_err, exp_a, first_a, last_a;
   logic [1:0] last_d;

   gb_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .FILTER(2)) dut (
      .clk(clk), .rst(rst), .idata(idata), .iclk(iclk), .ihsync(ihsync), .ivsync(ivsync),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .frame_start(frame_start),
      .line_err(line_err), .frame_err(frame_err), .locked(locked)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (wr_cnt == 0) first_a = int'(wr_addr);
            last_a = int'(wr_addr);
            last_d = wr_data;
            if (int'(wr_addr) != exp_a) seq_err++;
            exp_a++;
            wr_cnt++;
         end
         if (frame_start) fs_cnt++;
         if (line_err) le_cnt++;
         if (frame_err) fe_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      wr_cnt = 0; fs_cnt = 0; le_cnt = 0; fe_cnt = 0; seq_err = 0; exp_a = 0;
      first_a = -1; last_a = -1; last_d = 2'bxx;
   endtask

   task automatic pix(input logic [1:0] d);
      idata = d;
      iclk = 1'b0;
      tick(3);
      iclk = 1'b1;
      tick(3);
   endtask

   task automatic hs();
      ihsync = 1'b1;
      tick(4);
      ihsync = 1'b0;
      tick(4);
   endtask

   task automatic vs();
      ivsync = 1'b1;
      tick(4);
      ivsync = 1'b0;
      tick(4);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      tick(3);
      tests++;
      if ({wr_addr, wr_data, wr_en, frame_start, line_err, frame_err, locked} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got addr=%0d data=%0d en=%b fs=%b le=%b fe=%b lk=%b expected all 0",
                  wr_addr, wr_data, wr_en, frame_start, line_err, frame_err, locked);
      end
      rst = 1'b0;
      clr();
      tick(2);
      tests++;
      if (wr_en !== 1'b0 || locked !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: got en=%b lk=%b expected 0 0", wr_en, locked);
      end
   endtask

   task automatic test_glitch();
      clr();
      iclk = 1'b0;
      tick(1);
      iclk = 1'b1;
      tick(10);
      chk("glitch_no_write", wr_cnt, 0);
      pix(2'b01);
      tick(8);
      chk("unarmed_no_write", wr_cnt, 0);
   endtask

   task automatic test_latency();
      clr();
      vs();
      tick(6);
      chk("arm_frame_start", fs_cnt, 1);
      chk("arm_no_frame_err", fe_cnt, 0);
      idata = 2'b10;
      iclk = 1'b0;
      tick(5);
      tests++;
      if (wr_en !== 1'b0) begin
         fails++;
         $display("FAIL latency_early: got wr_en=%b expected 0", wr_en);
      end
      tick(1);
      tests++;
      if (wr_en !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 2'b01) begin
         fails++;
         $display("FAIL latency_write: got en=%b addr=%0d data=%0d expected 1 0 1", wr_en, wr_addr, wr_data);
      end
      tick(1);
      tests++;
      if (wr_en !== 1'b0 || wr_data !== 2'b01) begin
         fails++;
         $display("FAIL single_cycle_hold: got en=%b data=%0d expected 0 1", wr_en, wr_data);
      end
      iclk = 1'b1;
      tick(4);
   endtask

   task automatic test_line();
      vs();
      tick(6);
      clr();
      for (int i = 0; i < H; i++) pix(2'b01);
      hs();
      tick(6);
      chk("line_writes", wr_cnt, H);
      chk("line_first", first_a, 0);
      chk("line_last", last_a, H - 1);
      chk("line_data", int'(last_d), 2);
      chk("line_seq", seq_err, 0);
      chk("line_no_err", le_cnt, 0);
   endtask

   task automatic test_frame();
      clr();
      vs();
      tick(6);
      chk("short_frame_err", fe_cnt, 1);
      clr();
      for (int r = 0; r < V; r++) begin
         for (int c = 0; c < H; c++) pix(2'(c % 3));
         hs();
      end
      chk("frame_writes", wr_cnt, H * V);
      chk("frame_last", last_a, H * V - 1);
      chk("frame_last_data", int'(last_d), 3);
      chk("frame_seq", seq_err, 0);
      vs();
      tick(6);
      chk("frame_no_err", fe_cnt + le_cnt, 0);
      chk("frame_locked", int'(locked), 1);
   endtask

   task automatic test_long_line();
      clr();
      for (int i = 0; i < H + 1; i++) pix(2'b00);
      tick(6);
      chk("long_writes", wr_cnt, H);
      chk("long_locked_before", int'(locked), 1);
      hs();
      tick(6);
      chk("long_line_err", le_cnt, 1);
      chk("long_unlocked", int'(locked), 0);
   endtask

   task automatic test_simul();
      clr();
      idata = 2'b11;
      ivsync = 1'b1;
      iclk = 1'b0;
      tick(3);
      iclk = 1'b1;
      tick(1);
      ivsync = 1'b0;
      tick(3);
      pix(2'b00);
      tick(6);
      chk("simul_writes", wr_cnt, 2);
      chk("simul_first", first_a, 0);
      chk("simul_last", last_a, 1);
      chk("simul_data", int'(last_d), 3);
      chk("simul_frame_start", fs_cnt, 1);
   endtask

   task automatic test_reset_mid();
      vs();
      for (int i = 0; i < 80; i++) pix(2'b01);
      #2 rst = 1'b1;
      tick(2);
      rst = 1'b0;
      clr();
      for (int i = 0; i < 20; i++) pix(2'b01);
      tick(6);
      chk("midrst_no_write", wr_cnt, 0);
      chk("midrst_unlocked", int'(locked), 0);
      vs();
      pix(2'b01);
      tick(6);
      chk("midrst_writes", wr_cnt, 1);
      chk("midrst_addr", first_a, 0);
      chk("midrst_data", int'(last_d), 2);
   endtask

   initial begin
      clr();
      test_reset();
      test_glitch();
      test_latency();
      test_line();
      test_frame();
      test_long_line();
      test_simul();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
